rr_grant_arbiter: RTL and testbench
===================================

# rr_grant_arbiter

- Round-robin arbiter for one output port of the 5-port router.
- Takes request lines from the five input ports and produces the one-hot grant lines `g00`..`g04`.
- The crossbar selector consumes these grant lines to steer that output.
- Holds a grant for a whole packet (head to tail), then rotates priority so every input port is served fairly.

## Interface

Parameters:

- `MAX_HOLD`, default 0: maximum number of consecutive cycles one grant may be held. 0 means unlimited. Legal range is 0..255.

Ports:

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 5: request from each input port. Bit 0 = local, 1 = N, 2 = E, 3 = S, 4 = W.
- `tail_xfer` in 1: the tail flit of the currently granted packet is accepted downstream this cycle.
- `g00`..`g04` out 1 each: registered one-hot grant. `g0i` corresponds to `req[i]`.
- `grant_valid` out 1: OR of `g00`..`g04`.
- `grant_idx` out 3: index of the granted port. Reads 0 when `grant_valid` = 0.

## Operation

Reset state, applied asynchronously:

- `g00`..`g04` = 0, `grant_valid` = 0, `grant_idx` = 0.
- Priority pointer `ptr` = 0, hold counter = 0, FSM in IDLE.

State machine:

- **IDLE**: no grant.
  - If `req` ≠ 0, pick the winner by searching indices `ptr`, `ptr`+1, … modulo 5. The first set bit wins.
  - Load its one-hot grant and go to BUSY.
  - If `req` = 0, stay in IDLE.
- **BUSY**: the grant for index `w` is held unchanged.
  - Requests from other ports are ignored.
- **Release from BUSY** occurs on any of these conditions:
  - (a) `tail_xfer` = 1;
  - (b) `req[w]` = 0 (abort or withdrawal);
  - (c) `MAX_HOLD` ≠ 0 and hold counter = `MAX_HOLD`−1.
- **On release**:
  - `ptr` becomes (`w`+1) mod 5.
  - In the same cycle, re-arbitrate over the current `req` using the new pointer. The search therefore gives index `w` the lowest priority.
  - If there is a winner, load its grant and remain in BUSY (back-to-back, with no idle bubble). If there is none, clear the grant and go to IDLE.
- **Hold counter**:
  - Cleared on every new grant.
  - Increments each cycle in BUSY without release.
  - Saturates at 255.
- **Simultaneous release conditions** ((a), (b) and (c) together) count as a single release. The pointer advances once.
- **Pointer rules**:
  - The pointer only changes on release. Entering BUSY from IDLE does not move it.
  - Wrap-around: `w` = 4 gives `ptr` = 0.
- **Invariant**: at most one of `g00`..`g04` is ever high. A grant is never issued to a port whose `req` bit was 0 at the sampling edge.

## Timing

- Latency: a request sampled at edge n gives a grant visible after edge n (a registered output, valid during cycle n+1).
- Release: `tail_xfer`/`req` drop sampled at edge k means the old grant is gone after edge k. Any next grant appears at the same edge.
- All outputs come directly from flops. There is no combinational path from `req` or `tail_xfer` to the outputs.
- Reset mid-packet: grant lines drop immediately (asynchronously) and the pointer returns to 0. After deassertion, arbitration restarts from IDLE on the first edge.
- `tail_xfer` while in IDLE is ignored.

## Test plan

- **Reset**: assert `rst` with `req`=5'b11111 → all `g0i`=0, `grant_valid`=0, `grant_idx`=0. Release `rst` → on the next edge `g00`=1, `grant_idx`=0.
- **Single requester**: `req`=5'b00100 for 4 cycles, then `tail_xfer`=1 for 1 cycle → `g02`=1 from cycle 1, held until the tail edge.
  - If `req` is still set, `g02` is re-granted back-to-back (the only requester).
  - `ptr`=3 afterwards.
- **Fair rotation**: `req`=5'b11111 held, `tail_xfer` pulsed every 3rd cycle → grants in order `g00`,`g01`,`g02`,`g03`,`g04`,`g00`, each lasting 3 cycles with no gaps.
- **Abort**: `req`=5'b01010 and `g01` granted; drop `req[1]` with no tail → next edge `g03`=1 and `ptr`=2.
- **Timeout**: `MAX_HOLD`=4, `req`=5'b10001, no `tail_xfer` → `g00` for 4 cycles, then `g04` for 4 cycles, then `g00`. Repeats indefinitely.
- **Idle return**: `req`=5'b10000, tail, then `req`=0 → `g04` drops, `grant_valid`=0, FSM in IDLE, `ptr`=0 (wrap-around).

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin packet arbiter for one router output; ports clk, rst, req[4:0], tail_xfer in; g00..g04, grant_valid, grant_idx out
module rr_grant_arbiter #(
  parameter int MAX_HOLD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic       tail_xfer,
  output logic       g00,
  output logic       g01,
  output logic       g02,
  output logic       g03,
  output logic       g04,
  output logic       grant_valid,
  output logic [2:0] grant_idx
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state_q, state_d;
  logic [4:0] grant_q, grant_d;
  logic [2:0] ptr_q, ptr_d, idx_q, idx_d, arb_ptr;
  logic [7:0] hold_q, hold_d;
  logic       valid_q, valid_d, rel;
  logic [3:0] pk;
  function automatic logic [3:0] pick(input logic [4:0] r, input logic [2:0] p);
    logic [3:0] res;
    int j;
    res = '0;
    for (int k = 4; k >= 0; k--) begin
      j = (int'(p) + k) % 5;
      if (r[j]) res = {1'b1, 3'(j)};
    end
    return res;
  endfunction
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    rel     = state_q == BUSY && (tail_xfer || !req[idx_q] ||
              (MAX_HOLD != 0 && int'(hold_q) == MAX_HOLD - 1));
    // On release the holder drops to lowest priority before re-arbitrating
    arb_ptr = rel ? (idx_q == 3'd4 ? 3'd0 : idx_q + 3'd1) : ptr_q;
    pk      = pick(req, arb_ptr);
    if (state_q == IDLE || rel) begin
      ptr_d   = arb_ptr;
      state_d = pk[3] ? BUSY : IDLE;
      grant_d = pk[3] ? 5'(5'b1 << pk[2:0]) : 5'b0;
      idx_d   = pk[3] ? pk[2:0] : 3'd0;
      valid_d = pk[3];
      hold_d  = '0;
    end else begin
      hold_d  = hold_q == 8'd255 ? hold_q : hold_q + 8'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end
  assign {g04, g03, g02, g01, g00} = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: vector table, timeout sequence and random run against a reference model
module tb_rr_grant_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = '0;
  logic       tail_xfer = 1'b0;
  logic a0, a1, a2, a3, a4, av, b0, b1, b2, b3, b4, bv;
  logic [2:0] ai, bi;
  int checks = 0;
  int errors = 0;
  int own[2];
  int ptr[2];
  int hold[2];
  int mh[2] = '{0, 4};
  typedef struct {
    logic [4:0] req;
    logic       tail;
    logic [4:0] exp_g;
  } vec_t;
  vec_t tbl[31];

  rr_grant_arbiter #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .tail_xfer(tail_xfer),
    .g00(a0), .g01(a1), .g02(a2), .g03(a3), .g04(a4),
    .grant_valid(av), .grant_idx(ai));
  rr_grant_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .tail_xfer(tail_xfer),
    .g00(b0), .g01(b1), .g02(b2), .g03(b3), .g04(b4),
    .grant_valid(bv), .grant_idx(bi));

  always #5 clk = ~clk;

  function automatic logic [8:0] out0();
    return {av, ai, a4, a3, a2, a1, a0};
  endfunction
  function automatic logic [8:0] out4();
    return {bv, bi, b4, b3, b2, b1, b0};
  endfunction
  function automatic logic [8:0] enc(input int o);
    if (o < 0) return 9'd0;
    return {1'b1, 3'(o), 5'(5'b1 << o)};
  endfunction
  function automatic logic [8:0] from_onehot(input logic [4:0] g);
    for (int i = 0; i < 5; i++) if (g == 5'(5'b1 << i)) return enc(i);
    return 9'd0;
  endfunction
  function automatic int search(input logic [4:0] r, input int p);
    for (int k = 0; k < 5; k++) if (r[(p + k) % 5]) return (p + k) % 5;
    return -1;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      own[i] = -1; ptr[i] = 0; hold[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (own[i] < 0) begin
        own[i] = search(req, ptr[i]);
        hold[i] = 0;
      end else if (tail_xfer || !req[own[i]] || (mh[i] != 0 && hold[i] == mh[i] - 1)) begin
        ptr[i] = (own[i] + 1) % 5;
        own[i] = search(req, ptr[i]);
        hold[i] = 0;
      end else if (hold[i] < 255) hold[i]++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model0", out0(), enc(own[0]));
    check("model4", out4(), enc(own[1]));
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    check("rst0", out0(), 9'd0);
    check("rst4", out4(), 9'd0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    tbl = '{
      '{5'b11111, 1'b0, 5'b00001}, '{5'b11111, 1'b0, 5'b00001}, '{5'b11111, 1'b1, 5'b00010},
      '{5'b11111, 1'b0, 5'b00010}, '{5'b11111, 1'b0, 5'b00010}, '{5'b11111, 1'b1, 5'b00100},
      '{5'b11111, 1'b0, 5'b00100}, '{5'b11111, 1'b0, 5'b00100}, '{5'b11111, 1'b1, 5'b01000},
      '{5'b11111, 1'b0, 5'b01000}, '{5'b11111, 1'b0, 5'b01000}, '{5'b11111, 1'b1, 5'b10000},
      '{5'b11111, 1'b0, 5'b10000}, '{5'b11111, 1'b0, 5'b10000}, '{5'b11111, 1'b1, 5'b00001},
      '{5'b01010, 1'b0, 5'b00010}, '{5'b01010, 1'b0, 5'b00010}, '{5'b01000, 1'b0, 5'b01000},
      '{5'b01000, 1'b0, 5'b01000}, '{5'b00100, 1'b0, 5'b00100}, '{5'b00100, 1'b0, 5'b00100},
      '{5'b00100, 1'b0, 5'b00100}, '{5'b00100, 1'b0, 5'b00100}, '{5'b00100, 1'b1, 5'b00100},
      '{5'b00000, 1'b0, 5'b00000}, '{5'b00000, 1'b1, 5'b00000}, '{5'b11111, 1'b0, 5'b01000},
      '{5'b10000, 1'b0, 5'b10000}, '{5'b10000, 1'b1, 5'b10000}, '{5'b00000, 1'b0, 5'b00000},
      '{5'b11111, 1'b0, 5'b00001}
    };
    model_reset();
    rst = 1'b1;
    req = 5'b11111;
    #12;
    check("reset_hold0", out0(), 9'd0);
    check("reset_hold4", out4(), 9'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("first_grant", out0(), from_onehot(5'b00001));
    foreach (tbl[n]) begin
      req = tbl[n].req;
      tail_xfer = tbl[n].tail;
      tick();
      check($sformatf("vec%0d", n), out0(), from_onehot(tbl[n].exp_g));
    end
    tail_xfer = 1'b0;
    req = 5'b10001;
    async_reset();
    for (int n = 1; n <= 16; n++) begin
      tick();
      check($sformatf("timeout%0d", n), out4(), from_onehot(((n - 1) / 4) % 2 == 0 ? 5'b00001 : 5'b10000));
      check($sformatf("nolimit%0d", n), out0(), from_onehot(5'b00001));
    end
    for (int n = 0; n < 3000; n++) begin
      req = $urandom_range(0, 3) == 0 ? 5'($urandom) & 5'($urandom) : 5'($urandom);
      tail_xfer = $urandom_range(0, 4) == 0;
      if ($urandom_range(0, 199) == 0) async_reset();
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
